disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter DIGIT_CYCLES, default 100000: clock cycles each digit is driven (ON slot); SHALL be >= 1.
REQ-002 Parameter BLANK_CYCLES, default 1000: clock cycles of anti-ghosting blank before each ON slot; SHALL be >= 1.
REQ-003 clk  input  1  system clock; one clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in0..in5  input  6 each  digit word {en, hex[3:0], dp_n}: en=1 lights the digit, hex is the value, dp_n=0 lights the decimal point; in0 is the rightmost digit.
REQ-006 sseg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-007 dp  output  1  active-low decimal point.
REQ-008 an  output  6  active-low digit enables; an[i] selects digit i.
REQ-009 frame_tick  output  1  one-cycle pulse marking a shadow-register load.
REQ-010 digit_idx  output  3  index (0..5) of the digit slot currently in progress.

Function
REQ-011 FSM states: BLANK and ON; per-state cycle counter cnt, width $clog2(max(DIGIT_CYCLES,BLANK_CYCLES)).
REQ-012 BLANK lasts exactly BLANK_CYCLES cycles, then the FSM enters ON with cnt=0 and unchanged digit_idx.
REQ-013 ON lasts exactly DIGIT_CYCLES cycles, then the FSM enters BLANK with cnt=0 and digit_idx incremented.
REQ-014 digit_idx wraps from 5 to 0; the frame period is 6*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
REQ-015 On the last BLANK cycle with digit_idx=0, the six shadow registers SHALL load in0..in5, and frame_tick SHALL be 1 in that cycle only.
REQ-016 The display SHALL be driven only from the shadow registers; input changes mid-frame have no visible effect until the next load.
REQ-017 In BLANK: an=6'b111111, sseg=7'b1111111, dp=1.
REQ-018 In ON with shadow[idx].en=1: an = all ones except bit idx = 0, sseg = decode(shadow[idx].hex), dp = shadow[idx].dp_n.
REQ-019 In ON with shadow[idx].en=0: an=6'b111111, sseg=7'b1111111, dp=1; slot timing is unchanged.
REQ-020 Decode is the standard active-low hex table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 an, sseg, dp, frame_tick SHALL be registered outputs, decoded from next-state, so they change on the same edge as the state transition and never glitch.
REQ-022 Only one bit of an SHALL be low in any cycle; an SHALL be all ones for at least BLANK_CYCLES cycles between two different digits.

Reset
REQ-023 While reset=1: state=BLANK, cnt=0, digit_idx=0, all shadow registers=0, an=6'b111111, sseg=7'b1111111, dp=1, frame_tick=0.
REQ-024 After reset is released, the first shadow load and frame_tick occur on the BLANK_CYCLES-th cycle; the first ON slot follows immediately.
REQ-025 Reset asserted mid-ON SHALL force all outputs to the blank values asynchronously, with no partial-slot output after release.

Verification (DIGIT_CYCLES=4, BLANK_CYCLES=2, frame = 36 cycles)
REQ-026 Reset, then in0..in5 = {1,hex i,1} for i=0..5 -> frame_tick at cycle 2; each ON slot is 4 cycles; an cycles 111110, 111101, ... 011111; sseg matches the digits 0..5; an stays all ones for 2 cycles between slots.
REQ-027 Run 3 frames -> frame_tick spacing is exactly 36 cycles; digit_idx wraps 5->0; no cycle has more than one an bit low.
REQ-028 Change in3 to {1,F,0} while digit_idx=1 -> digit 3 still shows the old value this frame; the next frame shows sseg=0001110 with dp=0.
REQ-029 in2.en=0 -> during slot 2, an=111111 and sseg=1111111 for 4 cycles; slots 3 and 4 keep their nominal timing.
REQ-030 Assert reset during cycle 2 of slot 4 -> outputs go to the blank values immediately; after release, the REQ-024 timing is repeated from scratch.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Six-digit multiplexed seven-segment scan controller with per-slot anti-ghosting
// blank and a frame-synchronous shadow register bank feeding the display.
module disp_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] in0,
  input  logic [5:0] in1,
  input  logic [5:0] in2,
  input  logic [5:0] in3,
  input  logic [5:0] in4,
  input  logic [5:0] in5,
  output logic [6:0] sseg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_tick,
  output logic [2:0] digit_idx
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx_nxt;
  logic             load;
  logic [5:0]       in_w     [6];
  logic [5:0]       shadow   [6];
  logic [5:0]       word_nxt;
  logic [5:0]       an_nxt;
  logic [6:0]       sseg_nxt;
  logic             dp_nxt;
  logic             tick_nxt;

  function automatic logic [6:0] decode(input logic [3:0] hex);
    case (hex)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    in_w[0] = in0;
    in_w[1] = in1;
    in_w[2] = in2;
    in_w[3] = in3;
    in_w[4] = in4;
    in_w[5] = in5;
  end

  // The bank is captured on the final blank cycle of slot 0, so every frame
  // shows one coherent snapshot regardless of when the inputs move.
  assign load = (state == BLANK) && (cnt == BLANK_LAST) && (digit_idx == 3'd0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    idx_nxt   = digit_idx;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ON;
          cnt_nxt   = '0;
        end
      end
      ON: begin
        if (cnt == DIGIT_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge as
  // the FSM; the freshly loaded word is forwarded into the first slot.
  always_comb begin
    word_nxt = load ? in_w[idx_nxt] : shadow[idx_nxt];
    an_nxt   = 6'b111111;
    sseg_nxt = 7'b1111111;
    dp_nxt   = 1'b1;
    tick_nxt = (state_nxt == BLANK) && (cnt_nxt == BLANK_LAST) && (idx_nxt == 3'd0);
    if ((state_nxt == ON) && word_nxt[5]) begin
      an_nxt   = ~(6'b000001 << idx_nxt);
      sseg_nxt = decode(word_nxt[4:1]);
      dp_nxt   = word_nxt[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK;
      cnt        <= '0;
      digit_idx  <= 3'd0;
      an         <= 6'b111111;
      sseg       <= 7'b1111111;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
      // NOTE: the six-entry bank is small flop storage, so clearing it in reset is cheap and keeps the display defined.
      for (int i = 0; i < 6; i++) shadow[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digit_idx  <= idx_nxt;
      an         <= an_nxt;
      sseg       <= sseg_nxt;
      dp         <= dp_nxt;
      frame_tick <= tick_nxt;
      if (load) begin
        for (int i = 0; i < 6; i++) shadow[i] <= in_w[i];
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIGIT_CYCLES=4, BLANK_CYCLES=2 (36-cycle frame);
// expected outputs come from the frame position and a snapshot of the inputs.
module tb_disp_scan_ctrl;

  localparam int DC    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = 6 * SLOT;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] ins [6];
  logic [6:0] sseg;
  logic       dp;
  logic [5:0] an;
  logic       frame_tick;
  logic [2:0] digit_idx;

  int tests = 0;
  int fails = 0;
  int t;
  int last_tick;

  logic [5:0] m_sh [6];
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  disp_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .in0        (ins[0]),
    .in1        (ins[1]),
    .in2        (ins[2]),
    .in3        (ins[3]),
    .in4        (ins[4]),
    .in5        (ins[5]),
    .sseg       (sseg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick),
    .digit_idx  (digit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an"},   32'(an),         32'h3F);
    check({tag, "_sseg"}, 32'(sseg),       32'h7F);
    check({tag, "_dp"},   32'(dp),         32'h1);
    check({tag, "_tick"}, 32'(frame_tick), 32'h0);
    check({tag, "_idx"},  32'(digit_idx),  32'h0);
  endtask

  // Expected outputs at frame position p (p=0 is the first cycle after reset).
  task automatic check_pos(input int p);
    int k;
    int q;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    k     = p / SLOT;
    q     = p % SLOT;
    e_an  = 6'b111111;
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    if (q >= BC && m_sh[k][5]) begin
      e_an  = ~(6'b000001 << k);
      e_seg = seg_tab[m_sh[k][4:1]];
      e_dp  = m_sh[k][0];
    end
    check("an",        32'(an),         32'(e_an));
    check("sseg",      32'(sseg),       32'(e_seg));
    check("dp",        32'(dp),         32'(e_dp));
    check("frame_tick", 32'(frame_tick), (p == BC - 1) ? 32'h1 : 32'h0);
    check("digit_idx", 32'(digit_idx),  32'(k));
    check("an_onehot", ($countones(~an) <= 1) ? 32'h1 : 32'h0, 32'h1);
  endtask

  task automatic run(input int n);
    int p;
    repeat (n) begin
      @(posedge clk);
      #1;
      t++;
      p = t % FRAME;
      if (p == BC) begin
        for (int i = 0; i < 6; i++) m_sh[i] = ins[i];
      end
      check_pos(p);
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) check("tick_spacing", 32'(t - last_tick), 32'(FRAME));
        last_tick = t;
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    t         = 0;
    last_tick = -1;
    for (int i = 0; i < 6; i++) begin
      ins[i]  = {1'b1, 4'(i), 1'b1};
      m_sh[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_blank("reset");

    #2 reset = 1'b0;
    #1 check_pos(0);

    // Frame 1: digits 0..5; in3 changes while slot 1 is active.
    run(8);
    check("slot1_an", 32'(an), 32'h3D);
    ins[3] = {1'b1, 4'hF, 1'b0};
    run(14);
    check("f1_d3_sseg", 32'(sseg), 32'h30);
    check("f1_d3_dp",   32'(dp),   32'h1);
    run(14);

    // Frame 2: new in3 visible; disable digit 2 ahead of frame 3.
    run(10);
    ins[2][5] = 1'b0;
    run(12);
    check("f2_d3_sseg", 32'(sseg), 32'h0E);
    check("f2_d3_dp",   32'(dp),   32'h0);
    run(14);

    // Frame 3: slot 2 dark, slots 3 and 4 on nominal timing.
    run(16);
    check("f3_d2_an",   32'(an),   32'h3F);
    check("f3_d2_sseg", 32'(sseg), 32'h7F);
    run(20);

    // Frame 4: asynchronous reset in the second ON cycle of slot 4.
    run(27);
    check("pre_reset_an", 32'(an), 32'h2F);
    #2 reset = 1'b1;
    #1 check_blank("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_blank("held_reset");

    #2 reset = 1'b0;
    t         = 0;
    last_tick = -1;
    for (int i = 0; i < 6; i++) m_sh[i] = '0;
    #1 check_pos(0);
    run(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
